lc4_dual_issue_queue: RTL

Decode-stage instruction queue and pair-issue selector for the two-way superscalar LC4 pipeline. It buffers pre-decoded instructions arriving from fetch, up to two per cycle, in a 4-entry circular queue. Each cycle it presents the two oldest entries as pipe A (older) and pipe B (younger), and decides whether to issue both, only A, or none. Its register selectors drive the read ports of the dual-ported register file directly, and issued instructions proceed to execute.

---
 rtl/lc4_ss_pkg.sv | 46 ++++
 rtl/lc4_ss_pair_check.sv | 44 ++++
 rtl/lc4_dual_issue_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lc4_ss_pkg.sv
// Shared definitions for the LC4 superscalar decode queue: sizing, entry layout
// and hazard-cause encodings (also consumed by the performance counters).
package lc4_ss_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

    localparam int PC_LSB    = 0;
    localparam int INSN_LSB  = 16;
    localparam int RS_LSB    = 32;
    localparam int RT_LSB    = 35;
    localparam int RD_LSB    = 38;
    localparam int F_RS_RE   = 41;
    localparam int F_RT_RE   = 42;
    localparam int F_RD_WE   = 43;
    localparam int F_NZP_WE  = 44;
    localparam int F_IS_MEM  = 45;
    localparam int F_IS_CTRL = 46;
    localparam int F_VLD     = 47;
    localparam int ENTRY_W   = 48;

    typedef enum logic [2:0] {
        HZ_NONE = 3'd0,
        HZ_RAW  = 3'd1,
        HZ_NZP  = 3'd2,
        HZ_MEM  = 3'd3,
        HZ_CTRL = 3'd4
    } hz_cause_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [15:0] pc,
        input logic [15:0] insn,
        input logic [2:0]  rs,
        input logic [2:0]  rt,
        input logic [2:0]  rd,
        input logic        rs_re,
        input logic        rt_re,
        input logic        rd_we,
        input logic        nzp_we,
        input logic        is_mem,
        input logic        is_ctrl
    );
        return {1'b1, is_ctrl, is_mem, nzp_we, rd_we, rt_re, rs_re, rd, rt, rs, insn, pc};
    endfunction

endpackage

// File: rtl/lc4_ss_pair_check.sv
// Combinational pairing-hazard evaluation between the older (A) and younger (B)
// issue candidates.
module lc4_ss_pair_check
    import lc4_ss_pkg::*;
(
    input  logic [2:0] a_rd_i,
    input  logic       a_rd_we_i,
    input  logic       a_nzp_we_i,
    input  logic       a_is_mem_i,
    input  logic       a_is_ctrl_i,
    input  logic [2:0] b_rs_i,
    input  logic       b_rs_re_i,
    input  logic [2:0] b_rt_i,
    input  logic       b_rt_re_i,
    input  logic       b_is_mem_i,
    input  logic       b_is_ctrl_i,
    output logic       hazard_o
);

    hz_cause_e cause_s;
    logic      raw_s;

    assign raw_s = a_rd_we_i & ((b_rs_re_i & (b_rs_i == a_rd_i)) |
                                (b_rt_re_i & (b_rt_i == a_rd_i)));

    // First matching cause wins; only "any cause" matters for issue.
    always_comb begin
        cause_s = HZ_NONE;
        if (a_is_ctrl_i) begin
            cause_s = HZ_CTRL;
        end else if (raw_s) begin
            cause_s = HZ_RAW;
        end else if (a_nzp_we_i & b_is_ctrl_i) begin
            cause_s = HZ_NZP;
        end else if (a_is_mem_i & b_is_mem_i) begin
            cause_s = HZ_MEM;
        end else begin
            cause_s = HZ_NONE;
        end
    end

    assign hazard_o = (cause_s != HZ_NONE);

endmodule

// File: rtl/lc4_dual_issue_queue.sv
// Decode-stage circular instruction queue with pair-issue selection.
// Define LC4_DUAL_ISSUE_EN for two-wide issue; otherwise one entry per cycle.
module lc4_dual_issue_queue
    import lc4_ss_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic        i_valid_A,
    input  logic        i_valid_B,
    input  logic [15:0] i_pc_A,
    input  logic [15:0] i_insn_A,
    input  logic [2:0]  i_rs_A,
    input  logic [2:0]  i_rt_A,
    input  logic [2:0]  i_rd_A,
    input  logic        i_rs_re_A,
    input  logic        i_rt_re_A,
    input  logic        i_rd_we_A,
    input  logic        i_nzp_we_A,
    input  logic        i_is_mem_A,
    input  logic        i_is_ctrl_A,
    input  logic [15:0] i_pc_B,
    input  logic [15:0] i_insn_B,
    input  logic [2:0]  i_rs_B,
    input  logic [2:0]  i_rt_B,
    input  logic [2:0]  i_rd_B,
    input  logic        i_rs_re_B,
    input  logic        i_rt_re_B,
    input  logic        i_rd_we_B,
    input  logic        i_nzp_we_B,
    input  logic        i_is_mem_B,
    input  logic        i_is_ctrl_B,
    output logic        o_fetch_ready,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_valid_A,
    output logic [15:0] o_pc_A,
    output logic [15:0] o_insn_A,
    output logic [2:0]  o_rs_A,
    output logic [2:0]  o_rt_A,
    output logic [2:0]  o_rd_A,
    output logic        o_rd_we_A,
    output logic        o_nzp_we_A,
    output logic        o_is_mem_A,
    output logic        o_is_ctrl_A,
    output logic        o_valid_B,
    output logic [15:0] o_pc_B,
    output logic [15:0] o_insn_B,
    output logic [2:0]  o_rs_B,
    output logic [2:0]  o_rt_B,
    output logic [2:0]  o_rd_B,
    output logic        o_rd_we_B,
    output logic        o_nzp_we_B,
    output logic        o_is_mem_B,
    output logic        o_is_ctrl_B,
    output logic        o_split
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]   head1_s, tail1_s;
    logic [ENTRY_W-1:0] ent_a_s, ent_b_s;
    logic               fetch_ready_s, cand_a_s, cand_b_s;
    logic               valid_a_s, valid_b_s, hazard_s;
    logic               enq_a_s, enq_b_s;
    logic [CNT_W-1:0]   enq_n_s, deq_n_s;
    logic               unused_bits_s;

    assign head1_s = head_q + PTR_W'(1);
    assign tail1_s = tail_q + PTR_W'(1);
    assign ent_a_s = mem_q[head_q];
    assign ent_b_s = mem_q[head1_s];

    // Readiness looks only at the registered occupancy, never at this cycle's issue.
    assign fetch_ready_s = (count_q <= CNT_W'(DEPTH - 2));
    assign cand_a_s      = (count_q != CNT_W'(0));
    assign cand_b_s      = (count_q >= CNT_W'(2));

    assign enq_a_s = fetch_ready_s & i_valid_A;
    assign enq_b_s = enq_a_s & i_valid_B;
    assign enq_n_s = CNT_W'(enq_a_s) + CNT_W'(enq_b_s);

    assign valid_a_s = cand_a_s & ~i_stall & ~i_flush;
    assign deq_n_s   = CNT_W'(valid_a_s) + CNT_W'(valid_b_s);

    lc4_ss_pair_check u_pair_check (
        .a_rd_i      (ent_a_s[RD_LSB +: 3]),
        .a_rd_we_i   (ent_a_s[F_RD_WE]),
        .a_nzp_we_i  (ent_a_s[F_NZP_WE]),
        .a_is_mem_i  (ent_a_s[F_IS_MEM]),
        .a_is_ctrl_i (ent_a_s[F_IS_CTRL]),
        .b_rs_i      (ent_b_s[RS_LSB +: 3]),
        .b_rs_re_i   (ent_b_s[F_RS_RE]),
        .b_rt_i      (ent_b_s[RT_LSB +: 3]),
        .b_rt_re_i   (ent_b_s[F_RT_RE]),
        .b_is_mem_i  (ent_b_s[F_IS_MEM]),
        .b_is_ctrl_i (ent_b_s[F_IS_CTRL]),
        .hazard_o    (hazard_s)
    );

`ifdef LC4_DUAL_ISSUE_EN
    assign valid_b_s     = cand_b_s & valid_a_s & ~hazard_s;
    assign o_split       = valid_a_s & cand_b_s & ~valid_b_s;
    assign unused_bits_s = ^{ent_a_s[F_RS_RE], ent_a_s[F_RT_RE], ent_a_s[F_VLD], ent_b_s[F_VLD]};
`else
    assign valid_b_s     = 1'b0;
    assign o_split       = valid_a_s & cand_b_s;
    assign unused_bits_s = ^{ent_a_s[F_RS_RE], ent_a_s[F_RT_RE], ent_a_s[F_VLD], ent_b_s[F_VLD],
                             hazard_s};
`endif

    // Pointer and occupancy next state; flush overrides both enqueue and issue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_n_s);
            tail_d  = tail_q + PTR_W'(enq_n_s);
            count_d = count_q + enq_n_s - deq_n_s;
        end
    end

    // State register and entry storage, frozen while gwe is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (gwe) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_a_s && !i_flush) begin
                mem_q[tail_q] <= pack_entry(i_pc_A, i_insn_A, i_rs_A, i_rt_A, i_rd_A,
                                            i_rs_re_A, i_rt_re_A, i_rd_we_A, i_nzp_we_A,
                                            i_is_mem_A, i_is_ctrl_A);
            end
            if (enq_b_s && !i_flush) begin
                mem_q[tail1_s] <= pack_entry(i_pc_B, i_insn_B, i_rs_B, i_rt_B, i_rd_B,
                                             i_rs_re_B, i_rt_re_B, i_rd_we_B, i_nzp_we_B,
                                             i_is_mem_B, i_is_ctrl_B);
            end
        end
    end

    assign o_fetch_ready = fetch_ready_s;

    assign o_valid_A   = valid_a_s;
    assign o_pc_A      = ent_a_s[PC_LSB +: 16];
    assign o_insn_A    = ent_a_s[INSN_LSB +: 16];
    assign o_rs_A      = ent_a_s[RS_LSB +: 3];
    assign o_rt_A      = ent_a_s[RT_LSB +: 3];
    assign o_rd_A      = ent_a_s[RD_LSB +: 3];
    assign o_rd_we_A   = ent_a_s[F_RD_WE]   & valid_a_s;
    assign o_nzp_we_A  = ent_a_s[F_NZP_WE]  & valid_a_s;
    assign o_is_mem_A  = ent_a_s[F_IS_MEM]  & valid_a_s;
    assign o_is_ctrl_A = ent_a_s[F_IS_CTRL] & valid_a_s;

    assign o_valid_B   = valid_b_s;
    assign o_pc_B      = ent_b_s[PC_LSB +: 16];
    assign o_insn_B    = ent_b_s[INSN_LSB +: 16];
    assign o_rs_B      = ent_b_s[RS_LSB +: 3];
    assign o_rt_B      = ent_b_s[RT_LSB +: 3];
    assign o_rd_B      = ent_b_s[RD_LSB +: 3];
    assign o_rd_we_B   = ent_b_s[F_RD_WE]   & valid_b_s;
    assign o_nzp_we_B  = ent_b_s[F_NZP_WE]  & valid_b_s;
    assign o_is_mem_B  = ent_b_s[F_IS_MEM]  & valid_b_s;
    assign o_is_ctrl_B = ent_b_s[F_IS_CTRL] & valid_b_s;

endmodule
